ahblite_busmatrix_arbiter_rr2: RTL and testbench

//  Two-master (SYS, DMA) arbiter for one AHB-lite bus-matrix output stage.

---
 rtl/ahblite_busmatrix_pkg.sv | 37 +++
 rtl/ahblite_burst_tracker.sv | 54 +++++
 rtl/ahblite_busmatrix_arbiter_rr2.sv | 111 +++++++++++
 tb/tb_ahblite_busmatrix_arbiter_rr2.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ahblite_busmatrix_pkg.sv
// Shared AHB-lite encodings and burst helpers for the bus-matrix output-stage arbiter.
// Consumers: ahblite_burst_tracker, ahblite_busmatrix_arbiter_rr2.
package ahblite_busmatrix_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] PORT_NONE = 2'b00;
  localparam logic [1:0] PORT_SYS  = 2'b01;
  localparam logic [1:0] PORT_DMA  = 2'b10;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

  function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len_m1 = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len_m1 = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_len_m1 = 4'd15;
      default:                      burst_len_m1 = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahblite_burst_tracker.sv
// Beat counter and re-arbitration boundary detect for one AHB-lite output stage.
// BOUNDARY is only ever asserted while HREADY_OUT=1.
module ahblite_burst_tracker
  import ahblite_busmatrix_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADY_OUT,
  input  logic       HSEL_OUT,
  input  logic [1:0] HTRANS_OUT,
  input  logic [2:0] HBURST_OUT,
  input  logic       arb_idle,
  input  logic       owner_req,
  output logic       BOUNDARY
);

  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic       accepted, is_nonseq, is_seq, last_beat, fixed_burst;

  always_comb begin
    accepted    = HREADY_OUT & HSEL_OUT & HTRANS_OUT[1];
    is_nonseq   = (HTRANS_OUT == HTRANS_NONSEQ);
    is_seq      = (HTRANS_OUT == HTRANS_SEQ);
    fixed_burst = (HBURST_OUT != HBURST_INCR);

    beat_cnt_d = beat_cnt_q;
    if (accepted && is_nonseq) begin
      beat_cnt_d = burst_len_m1(HBURST_OUT);
    end else if (accepted && is_seq && (beat_cnt_q != 4'd0)) begin
      beat_cnt_d = beat_cnt_q - 4'd1;
    end

    // Last beat: a SINGLE NONSEQ, or the SEQ that takes the counter to zero.
    last_beat = accepted &
                ((is_nonseq & (burst_len_m1(HBURST_OUT) == 4'd0)) |
                 (is_seq & (beat_cnt_q <= 4'd1)));

    BOUNDARY = HREADY_OUT &
               (arb_idle |
                ~HSEL_OUT |
                (HTRANS_OUT == HTRANS_IDLE) |
                (fixed_burst & last_beat) |
                ((HBURST_OUT == HBURST_INCR) & ~owner_req));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/ahblite_busmatrix_arbiter_rr2.sv
// Two-master (SYS/DMA) round-robin arbiter for one AHB-lite bus-matrix output stage.
// Define ARB_TENURE_LIMIT_EN for the sticky policy bounded by MAX_TENURE accepted beats.
module ahblite_busmatrix_arbiter_rr2
  import ahblite_busmatrix_pkg::*;
#(
  parameter int unsigned MAX_TENURE = 16
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       REQ_SYS,
  input  logic       REQ_DMA,
  input  logic       HREADY_OUT,
  input  logic       HSEL_OUT,
  input  logic [1:0] HTRANS_OUT,
  input  logic [2:0] HBURST_OUT,
  output logic [1:0] PORT_SEL,
  output logic       PORT_NOSEL
);

  arb_state_e state_q, state_d;
  logic [1:0] port_sel_q, port_sel_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic [1:0] grant;
  logic       owner_req;
  logic       boundary;

`ifdef ARB_TENURE_LIMIT_EN
  logic [7:0] tenure_q, tenure_d, tenure_inc;
  logic       other_req, accepted;
`endif

  ahblite_burst_tracker u_tracker (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HREADY_OUT (HREADY_OUT),
    .HSEL_OUT   (HSEL_OUT),
    .HTRANS_OUT (HTRANS_OUT),
    .HBURST_OUT (HBURST_OUT),
    .arb_idle   (state_q == ARB_IDLE),
    .owner_req  (owner_req),
    .BOUNDARY   (boundary)
  );

  always_comb begin
    state_d      = state_q;
    port_sel_d   = port_sel_q;
    last_grant_d = last_grant_q;
    owner_req    = (port_sel_q == PORT_DMA) ? REQ_DMA : REQ_SYS;

    if (REQ_SYS && REQ_DMA) begin
      grant = (last_grant_q == PORT_SYS) ? PORT_DMA : PORT_SYS;
    end else if (REQ_DMA) begin
      grant = PORT_DMA;
    end else begin
      grant = PORT_SYS;
    end

`ifdef ARB_TENURE_LIMIT_EN
    other_req  = (port_sel_q == PORT_DMA) ? REQ_SYS : REQ_DMA;
    accepted   = HREADY_OUT & HSEL_OUT & HTRANS_OUT[1];
    tenure_inc = (accepted && (tenure_q != 8'hFF)) ? tenure_q + 8'd1 : tenure_q;
    tenure_d   = (state_q == ARB_OWN) ? tenure_inc : '0;
    // The beat accepted at this edge counts toward the limit, so the owner gets exactly MAX_TENURE beats.
    if ((state_q == ARB_OWN) && owner_req &&
        !(other_req && (tenure_inc >= 8'(MAX_TENURE)))) begin
      grant = port_sel_q;
    end
`endif

    if (boundary) begin
      if (!REQ_SYS && !REQ_DMA) begin
        state_d = ARB_IDLE;
      end else begin
        state_d      = ARB_OWN;
        port_sel_d   = grant;
        last_grant_d = grant;
`ifdef ARB_TENURE_LIMIT_EN
        if ((state_q == ARB_IDLE) || (grant != port_sel_q)) begin
          tenure_d = '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ARB_IDLE;
      port_sel_q   <= PORT_NONE;
      last_grant_q <= PORT_DMA;
    end else begin
      state_q      <= state_d;
      port_sel_q   <= port_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef ARB_TENURE_LIMIT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tenure_q <= '0;
    end else begin
      tenure_q <= tenure_d;
    end
  end
`endif

  assign PORT_SEL   = port_sel_q;
  assign PORT_NOSEL = (state_q == ARB_IDLE);

endmodule

// File: tb/tb_ahblite_busmatrix_arbiter_rr2.sv
// Table-driven, scoreboard-checked bench for ahblite_busmatrix_arbiter_rr2 (MAX_TENURE=4).
// Expectations follow ARB_TENURE_LIMIT_EN where the two policies differ.
module tb_ahblite_busmatrix_arbiter_rr2;
  import ahblite_busmatrix_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       REQ_SYS, REQ_DMA, HREADY_OUT, HSEL_OUT;
  logic [1:0] HTRANS_OUT;
  logic [2:0] HBURST_OUT;
  logic [1:0] PORT_SEL;
  logic       PORT_NOSEL;

  always #5 HCLK = ~HCLK;

  ahblite_busmatrix_arbiter_rr2 #(.MAX_TENURE(4)) u_dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .REQ_SYS    (REQ_SYS),
    .REQ_DMA    (REQ_DMA),
    .HREADY_OUT (HREADY_OUT),
    .HSEL_OUT   (HSEL_OUT),
    .HTRANS_OUT (HTRANS_OUT),
    .HBURST_OUT (HBURST_OUT),
    .PORT_SEL   (PORT_SEL),
    .PORT_NOSEL (PORT_NOSEL)
  );

  typedef struct {
    bit         rst;
    bit         rs, rd, rdy, hsel;
    logic [1:0] tr;
    logic [2:0] hb;
    logic [1:0] esel;
    bit         enosel;
    int         tid;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic       nosel;
    int         tid;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] t3_exp [6];

  task automatic add(input int tid, input bit rst, rs, rd, rdy, hsel,
                     input logic [1:0] tr, input logic [2:0] hb,
                     input logic [1:0] esel, input bit enosel);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rd = rd; v.rdy = rdy; v.hsel = hsel;
    v.tr = tr; v.hb = hb; v.esel = esel; v.enosel = enosel; v.tid = tid;
    vecs.push_back(v);
  endtask

  task automatic expect_out(input logic [1:0] sel, input logic nosel, input int tid, input int idx);
    exp_t e;
    e.sel = sel; e.nosel = nosel; e.tid = tid; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected value queued");
      return;
    end
    e = sb.pop_front();
    if ((PORT_SEL !== e.sel) || (PORT_NOSEL !== e.nosel)) begin
      errors++;
      $display("FAIL t%0d_v%0d: PORT_SEL=%b PORT_NOSEL=%b, expected PORT_SEL=%b PORT_NOSEL=%b",
               e.tid, e.idx, PORT_SEL, PORT_NOSEL, e.sel, e.nosel);
    end
  endtask

  task automatic drive_idle();
    REQ_SYS = 1'b0; REQ_DMA = 1'b0; HREADY_OUT = 1'b1; HSEL_OUT = 1'b0;
    HTRANS_OUT = HTRANS_IDLE; HBURST_OUT = HBURST_SINGLE;
  endtask

  task automatic do_reset(input int tid);
    @(negedge HCLK);
    HRESETn = 1'b0;
    drive_idle();
    expect_out(PORT_NONE, 1'b1, tid, -1);
    #1 compare_head();
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic step(input bit rs, rd, rdy, hsel, input logic [1:0] tr, input logic [2:0] hb,
                      input logic [1:0] esel, input bit enosel, input int tid, input int idx);
    @(negedge HCLK);
    REQ_SYS = rs; REQ_DMA = rd; HREADY_OUT = rdy; HSEL_OUT = hsel;
    HTRANS_OUT = tr; HBURST_OUT = hb;
    expect_out(esel, enosel, tid, idx);
    @(posedge HCLK);
    #1 compare_head();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0;
    drive_idle();

`ifdef ARB_TENURE_LIMIT_EN
    t3_exp = '{PORT_SYS, PORT_SYS, PORT_SYS, PORT_SYS, PORT_DMA, PORT_DMA};
`else
    t3_exp = '{PORT_SYS, PORT_DMA, PORT_SYS, PORT_DMA, PORT_SYS, PORT_DMA};
`endif

    // 1: first grant after reset
    add(1, 1, 0, 0, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, PORT_NONE, 1);
    add(1, 0, 1, 0, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, PORT_SYS,  0);
    // 2: SYS INCR4, DMA requests from beat 2, handover after beat 4
    add(2, 0, 1, 0, 1, 1, HTRANS_NONSEQ, HBURST_INCR4,  PORT_SYS,  0);
    add(2, 0, 1, 1, 1, 1, HTRANS_SEQ,    HBURST_INCR4,  PORT_SYS,  0);
    add(2, 0, 1, 1, 1, 1, HTRANS_SEQ,    HBURST_INCR4,  PORT_SYS,  0);
    add(2, 0, 1, 1, 1, 1, HTRANS_SEQ,    HBURST_INCR4,  PORT_DMA,  0);
    // 3/6: both requesting, back-to-back singles
    for (int i = 0; i < 6; i++) begin
      add(3, (i == 0), 1, 1, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, t3_exp[i], 0);
    end
    // 4: DMA WRAP8 with a 3-cycle stall before beat 5; stall inputs would otherwise be a boundary
    add(4, 1, 0, 1, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, PORT_DMA, 0);
    add(4, 0, 1, 1, 1, 1, HTRANS_NONSEQ, HBURST_WRAP8,  PORT_DMA, 0);
    for (int i = 0; i < 3; i++) add(4, 0, 1, 1, 1, 1, HTRANS_SEQ, HBURST_WRAP8, PORT_DMA, 0);
    for (int i = 0; i < 3; i++) add(4, 0, 1, 0, 0, 0, HTRANS_IDLE, HBURST_SINGLE, PORT_DMA, 0);
    add(4, 0, 1, 1, 1, 1, HTRANS_SEQ,    HBURST_WRAP8,  PORT_DMA, 0);
    add(4, 0, 1, 0, 1, 1, HTRANS_SEQ,    HBURST_WRAP8,  PORT_DMA, 0);
    add(4, 0, 1, 0, 1, 1, HTRANS_SEQ,    HBURST_WRAP8,  PORT_DMA, 0);
    add(4, 0, 1, 0, 1, 1, HTRANS_SEQ,    HBURST_WRAP8,  PORT_SYS, 0);
    // 5: SYS undefined INCR with BUSY gaps, then IDLE; DMA INCR drops REQ mid-burst
    add(5, 0, 1, 1, 1, 1, HTRANS_NONSEQ, HBURST_INCR,   PORT_SYS, 0);
    add(5, 0, 1, 1, 1, 1, HTRANS_BUSY,   HBURST_INCR,   PORT_SYS, 0);
    add(5, 0, 1, 1, 1, 1, HTRANS_SEQ,    HBURST_INCR,   PORT_SYS, 0);
    add(5, 0, 1, 1, 1, 1, HTRANS_BUSY,   HBURST_INCR,   PORT_SYS, 0);
    add(5, 0, 1, 1, 1, 1, HTRANS_SEQ,    HBURST_INCR,   PORT_SYS, 0);
    add(5, 0, 0, 1, 1, 1, HTRANS_IDLE,   HBURST_INCR,   PORT_DMA, 0);
    add(5, 0, 1, 1, 1, 1, HTRANS_NONSEQ, HBURST_INCR,   PORT_DMA, 0);
    add(5, 0, 1, 1, 1, 1, HTRANS_SEQ,    HBURST_INCR,   PORT_DMA, 0);
    add(5, 0, 1, 0, 1, 1, HTRANS_SEQ,    HBURST_INCR,   PORT_SYS, 0);
    // 7: nobody requesting -> idle with PORT_SEL held; stall while idle; re-grant
    add(7, 0, 0, 0, 1, 1, HTRANS_IDLE,   HBURST_SINGLE, PORT_SYS, 1);
    add(7, 0, 0, 1, 0, 0, HTRANS_IDLE,   HBURST_SINGLE, PORT_SYS, 1);
    add(7, 0, 0, 1, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, PORT_DMA, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset(vecs[i].tid);
      step(vecs[i].rs, vecs[i].rd, vecs[i].rdy, vecs[i].hsel, vecs[i].tr, vecs[i].hb,
           vecs[i].esel, vecs[i].enosel, vecs[i].tid, i);
    end

    // 8: asynchronous reset in the middle of a DMA burst, then SYS wins the first tie
    step(0, 1, 1, 1, HTRANS_NONSEQ, HBURST_INCR4, PORT_DMA, 0, 8, 0);
    step(0, 1, 1, 1, HTRANS_SEQ,    HBURST_INCR4, PORT_DMA, 0, 8, 1);
    #3 HRESETn = 1'b0;
    expect_out(PORT_NONE, 1'b1, 8, 2);
    #1 compare_head();
    @(negedge HCLK);
    HRESETn = 1'b1;
    step(1, 1, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, PORT_SYS, 0, 8, 3);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
